// File: rtl/fetch_ctrl_if.sv
// Fetch-to-decode bus: instr_mem address/data, output buffer handshake,
// redirect request and status outputs of the fetch sequencer.
interface fetch_ctrl_if #(
  parameter int ADDR_LEN  = 8,
  parameter int INSTR_LEN = 32
);
  logic                 start_i;
  logic [ADDR_LEN-1:0]  pc_o;
  logic [INSTR_LEN-1:0] instr_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [INSTR_LEN-1:0] out_instr_o;
  logic [ADDR_LEN-1:0]  out_pc_o;
  logic                 redirect_i;
  logic [ADDR_LEN-1:0]  redirect_addr_i;
  logic                 halted_o;
  logic                 misalign_o;
  logic [15:0]          fetch_count_o;

  modport master (
    input  start_i, instr_i, out_ready_i, redirect_i, redirect_addr_i,
    output pc_o, out_valid_o, out_instr_o, out_pc_o, halted_o, misalign_o,
    fetch_count_o
  );

  modport slave (
    output start_i, instr_i, out_ready_i, redirect_i, redirect_addr_i,
    input  pc_o, out_valid_o, out_instr_o, out_pc_o, halted_o, misalign_o,
    fetch_count_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, buffers one instruction for decode,
// handles redirect/flush, halts on a self-loop and counts accepted instructions.
module fetch_ctrl #(
  parameter int                   ADDR_LEN   = 8,
  parameter int                   INSTR_LEN  = 32,
  parameter logic [ADDR_LEN-1:0]  RESET_PC   = '0,
  parameter logic [INSTR_LEN-1:0] HALT_INSTR = INSTR_LEN'(32'h0000006F)
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t               state_q, state_d;
  logic [ADDR_LEN-1:0]  pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic [INSTR_LEN-1:0] instr_q, instr_d;
  logic [ADDR_LEN-1:0]  out_pc_q, out_pc_d;
  logic                 misalign_q, misalign_d;
  logic [15:0]          count_q, count_d;
  logic                 accept;
  logic                 capture;
  logic                 is_halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      out_pc_q   <= '0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      out_pc_q   <= out_pc_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  // Redirect outranks everything; the accept count still advances in that cycle.
  always_comb begin
    accept     = valid_q & bus.out_ready_i;
    capture    = (state_q == RUN) & ~bus.redirect_i & (~valid_q | accept);
    is_halt    = (bus.instr_i == HALT_INSTR);
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    out_pc_d   = out_pc_q;
    misalign_d = misalign_q;
    count_d    = count_q;

    if (accept && count_q != 16'hFFFF)
      count_d = count_q + 16'd1;

    case (state_q)
      IDLE:    if (bus.start_i && !bus.redirect_i) state_d = RUN;
      RUN:     if (capture && is_halt) state_d = HALT;
      HALT:    if (bus.redirect_i) state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (bus.redirect_i) begin
      valid_d = 1'b0;
      pc_d    = {bus.redirect_addr_i[ADDR_LEN-1:2], 2'b00};
      if (bus.redirect_addr_i[1:0] != 2'b00)
        misalign_d = 1'b1;
    end else if (capture) begin
      instr_d  = bus.instr_i;
      out_pc_d = pc_q;
      valid_d  = 1'b1;
      // The self-loop stays at its own address so a later redirect is the only exit.
      if (!is_halt)
        pc_d = pc_q + ADDR_LEN'(4);
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.out_valid_o   = valid_q;
  assign bus.out_instr_o   = instr_q;
  assign bus.out_pc_o      = out_pc_q;
  assign bus.halted_o      = (state_q == HALT);
  assign bus.misalign_o    = misalign_q;
  assign bus.fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios followed by random traffic
// checked against a transaction-level model of the delivered instruction stream.
module tb_fetch_ctrl;
  localparam logic [31:0] HALT = 32'h0000006F;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem [64];
  int          n_checks;
  int          n_fail;

  logic [7:0]  exp_pc;
  logic [15:0] exp_cnt;
  logic        exp_mis;
  logic        halt_seen;
  int          deliveries;

  fetch_ctrl_if #(.ADDR_LEN(8), .INSTR_LEN(32)) bus ();

  fetch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.instr_i = mem[bus.pc_o[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic start, input logic ready,
                               input logic redir, input logic [7:0] addr);
    bus.start_i         = start;
    bus.out_ready_i     = ready;
    bus.redirect_i      = redir;
    bus.redirect_addr_i = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pc"},       32'(bus.pc_o), 32'h0);
    checkOutput({tag, "_valid"},    32'(bus.out_valid_o), 32'h0);
    checkOutput({tag, "_instr"},    bus.out_instr_o, 32'h0);
    checkOutput({tag, "_out_pc"},   32'(bus.out_pc_o), 32'h0);
    checkOutput({tag, "_halted"},   32'(bus.halted_o), 32'h0);
    checkOutput({tag, "_misalign"}, 32'(bus.misalign_o), 32'h0);
    checkOutput({tag, "_count"},    32'(bus.fetch_count_o), 32'h0);
  endtask

  task automatic resetModel();
    exp_pc     = 8'h00;
    exp_cnt    = 16'h0;
    exp_mis    = 1'b0;
    halt_seen  = 1'b0;
    deliveries = 0;
  endtask

  // Model of the delivered stream: each accepted instruction must be the next
  // sequential word after the last redirect, and nothing follows a delivered halt.
  task automatic runModelCycle();
    logic acc;
    acc = bus.out_valid_o & bus.out_ready_i;
    if (acc) begin
      deliveries++;
      checkOutput("delivery_after_halt", 32'(halt_seen), 32'h0);
      if (!halt_seen) begin
        checkOutput("stream_pc", 32'(bus.out_pc_o), 32'(exp_pc));
        checkOutput("stream_instr", bus.out_instr_o, mem[exp_pc[7:2]]);
        if (mem[exp_pc[7:2]] == HALT) begin
          checkOutput("halted_on_delivery", 32'(bus.halted_o), 32'h1);
          halt_seen = 1'b1;
        end else begin
          exp_pc = exp_pc + 8'd4;
        end
      end
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    if (bus.redirect_i) begin
      exp_pc    = {bus.redirect_addr_i[7:2], 2'b00};
      halt_seen = 1'b0;
      if (bus.redirect_addr_i[1:0] != 2'b00) exp_mis = 1'b1;
    end
    tick();
    checkOutput("fetch_count", 32'(bus.fetch_count_o), 32'(exp_cnt));
    checkOutput("misalign", 32'(bus.misalign_o), 32'(exp_mis));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetModel();
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    tick();
    tick();
    checkResetValues("reset");
    rst_n = 1'b1;

    // Start latency and back-to-back fetch
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("start_no_valid_yet", 32'(bus.out_valid_o), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("seq_instr", bus.out_instr_o, mem[i]);
      checkOutput("seq_out_pc", 32'(bus.out_pc_o), 32'(4 * i));
    end
    tick();
    checkOutput("seq_count", 32'(bus.fetch_count_o), 32'd4);
    checkOutput("seq_next_instr", bus.out_instr_o, 32'h1004);
    checkOutput("seq_pc", 32'(bus.pc_o), 32'h14);

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_instr", bus.out_instr_o, 32'h1004);
      checkOutput("stall_out_pc", 32'(bus.out_pc_o), 32'h10);
      checkOutput("stall_pc", 32'(bus.pc_o), 32'h14);
      checkOutput("stall_count", 32'(bus.fetch_count_o), 32'd4);
    end

    // Redirect while the buffer is accepted: counted, then flushed
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h20);
    tick();
    checkOutput("redir_flush_valid", 32'(bus.out_valid_o), 32'h0);
    checkOutput("redir_count", 32'(bus.fetch_count_o), 32'd5);
    checkOutput("redir_pc", 32'(bus.pc_o), 32'h20);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("redir_target_valid", 32'(bus.out_valid_o), 32'h1);
    checkOutput("redir_target_instr", bus.out_instr_o, 32'h1008);
    checkOutput("redir_target_out_pc", 32'(bus.out_pc_o), 32'h20);

    applyStimulus(1'b0, 1'b0, 1'b1, 8'h13);
    tick();
    checkOutput("misalign_pc", 32'(bus.pc_o), 32'h10);
    checkOutput("misalign_set", 32'(bus.misalign_o), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    checkOutput("misalign_sticky", 32'(bus.misalign_o), 32'h1);

    // Halt on the self-loop at word 2, then resume via redirect
    mem[2] = HALT;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    checkOutput("halt_redir_pc", 32'(bus.pc_o), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    tick();
    tick();
    checkOutput("halt_state", 32'(bus.halted_o), 32'h1);
    checkOutput("halt_instr", bus.out_instr_o, HALT);
    checkOutput("halt_out_pc", 32'(bus.out_pc_o), 32'h8);
    checkOutput("halt_pc", 32'(bus.pc_o), 32'h8);
    tick();
    tick();
    checkOutput("halt_no_capture", 32'(bus.out_valid_o), 32'h0);
    checkOutput("halt_pc_hold", 32'(bus.pc_o), 32'h8);
    checkOutput("halt_still", 32'(bus.halted_o), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    checkOutput("resume_halted", 32'(bus.halted_o), 32'h0);
    checkOutput("resume_pc", 32'(bus.pc_o), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("resume_out_pc", 32'(bus.out_pc_o), 32'h0);
    checkOutput("resume_instr", bus.out_instr_o, 32'h11);

    // PC wrap from the top of the address space
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFC);
    tick();
    checkOutput("wrap_pc", 32'(bus.pc_o), 32'hFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("wrap_out_pc_fc", 32'(bus.out_pc_o), 32'hFC);
    checkOutput("wrap_instr_fc", bus.out_instr_o, 32'h103F);
    checkOutput("wrap_pc_zero", 32'(bus.pc_o), 32'h0);
    tick();
    checkOutput("wrap_out_pc_00", 32'(bus.out_pc_o), 32'h0);
    checkOutput("wrap_instr_00", bus.out_instr_o, 32'h11);

    // Asynchronous reset in the middle of the stream
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();

    // Random traffic against the stream model
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(15) == 0) ? HALT : $urandom;
    resetModel();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(1'($urandom_range(1)), $urandom_range(3) != 0,
                    $urandom_range(15) == 0, 8'($urandom));
      runModelCycle();
    end
    checkOutput("random_made_progress", 32'(deliveries != 0), 32'h1);

    // Counter saturation
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000 + 32'(i);
    resetModel();
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 65545; c++) runModelCycle();
    checkOutput("count_saturated", 32'(bus.fetch_count_o), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
